// File: rtl/rv32i_types.sv
// Shared fetch-side types: line-buffer FSM states, line geometry and the
// 32-bit half-select used for instruction words.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    RESP
  } ilb_state_t;

  localparam int ILB_LINE_BYTES  = 32;
  localparam int ILB_OFFSET_BITS = 5;

  function automatic logic [31:0] ilb_word_sel(input logic [63:0] beat, input logic half);
    return half ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/ifetch_line_buffer.sv
// Single-line instruction buffer: 1-cycle hit, burst refill on miss, flush drops pending response.
// Optional hit/miss counters when IFETCH_LINE_BUFFER_STATS_EN is defined.
module ifetch_line_buffer
  import rv32i_types::*;
#(
  parameter int LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic        flush,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
`ifdef IFETCH_LINE_BUFFER_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int BW  = $clog2(LINE_BEATS);
  localparam int OFF = BW + 3;
  localparam int TW  = 32 - OFF;

  ilb_state_t    r_state;
  logic          r_valid;
  logic [TW-1:0] r_tag;
  logic [63:0]   r_data [LINE_BEATS];
  logic [BW-1:0] r_beat_cnt;
  logic          r_drop;
  logic [31:0]   r_addr;

  logic          w_lookup;
  logic          w_hit;
  logic          w_last_beat;
  logic          w_drop_now;
  logic [BW-1:0] w_hit_idx;
  logic [BW-1:0] w_fill_idx;
  logic [63:0]   w_fill_beat;
  logic          w_unused;

  // No lookup while a response is showing: fetch only moves its address after seeing imem_resp.
  assign w_lookup    = (r_state == IDLE) && (|imem_rmask) && !imem_resp;
  assign w_hit       = r_valid && (r_tag == imem_addr[31:OFF]);
  assign w_hit_idx   = imem_addr[OFF-1:3];
  assign w_fill_idx  = r_addr[OFF-1:3];
  assign w_last_beat = (r_beat_cnt == BW'(LINE_BEATS - 1));
  assign w_drop_now  = r_drop || flush;
  // The requested word may arrive on the final beat itself, so bypass the array.
  assign w_fill_beat = (w_fill_idx == r_beat_cnt) ? bmem_rdata : r_data[w_fill_idx];
  assign w_unused    = ^{imem_addr[1:0], r_addr[1:0]};

  always_ff @(posedge clk) begin
    if (r_state == FILL && bmem_rvalid) begin
      r_data[r_beat_cnt] <= bmem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_valid    <= 1'b0;
      r_tag      <= '0;
      r_beat_cnt <= '0;
      r_drop     <= 1'b0;
      r_addr     <= '0;
      imem_resp  <= 1'b0;
      imem_rdata <= '0;
      bmem_read  <= 1'b0;
      bmem_addr  <= '0;
    end else begin
      imem_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_lookup) begin
            if (w_hit) begin
              if (!flush) begin
                imem_resp  <= 1'b1;
                imem_rdata <= ilb_word_sel(r_data[w_hit_idx], imem_addr[2]);
              end
            end else begin
              r_addr     <= imem_addr;
              bmem_addr  <= {imem_addr[31:OFF], {OFF{1'b0}}};
              bmem_read  <= 1'b1;
              r_beat_cnt <= '0;
              r_state    <= REQ;
            end
          end
        end
        REQ: begin
          if (flush) r_drop <= 1'b1;
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            r_state   <= FILL;
          end
        end
        FILL: begin
          if (flush) r_drop <= 1'b1;
          if (bmem_rvalid) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_last_beat) begin
              r_valid <= 1'b1;
              r_tag   <= r_addr[31:OFF];
              r_state <= RESP;
              if (!w_drop_now) begin
                imem_resp  <= 1'b1;
                imem_rdata <= ilb_word_sel(w_fill_beat, r_addr[2]);
              end
            end
          end
        end
        RESP: begin
          r_drop  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_LINE_BUFFER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (w_lookup) begin
      if (w_hit && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 1'b1;
      if (!w_hit && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule
